// File: rtl/inst_memory_loader.sv
// Instruction memory loader: accepts one instruction word from a host and
// writes it into an asynchronous 16-bit SRAM as two halfwords. The low half
// goes to the even halfword address, the high half to the odd one.
module inst_memory_loader #(
  parameter int INST_DATA_WIDTH = 32,
  parameter int INST_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [INST_ADDR_WIDTH-1:0] wr_addr,
  input  logic [INST_DATA_WIDTH-1:0] wr_data,
  output logic                       wr_done,
  output logic [15:0]                word_count,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0] sram_dq,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic                       sram_lb_n,
  output logic                       sram_ub_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP_LO,
    WE_LO,
    HOLD_LO,
    SETUP_HI,
    WE_HI,
    HOLD_HI
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [INST_ADDR_WIDTH-1:0] r_addr;
  logic [INST_DATA_WIDTH-1:0] r_data;
  logic [SRAM_DATA_WIDTH-1:0] r_dq_out;
  logic                       r_dq_oe;
  logic                       w_accept;
  logic [INST_ADDR_WIDTH-1:0] w_src_addr;
  logic [INST_DATA_WIDTH-1:0] w_src_data;
  logic [SRAM_ADDR_WIDTH-1:0] w_base;
  logic                       w_next_hi;
  logic                       w_next_we;

  assign wr_ready = (r_state == IDLE);
  assign w_accept = wr_valid && wr_ready;
  assign sram_dq  = r_dq_oe ? r_dq_out : 'z;

  // Next-state logic: one handshake starts a fixed six-state write sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = SETUP_LO;
      SETUP_LO: w_next = WE_LO;
      WE_LO:    w_next = HOLD_LO;
      HOLD_LO:  w_next = SETUP_HI;
      SETUP_HI: w_next = WE_HI;
      WE_HI:    w_next = HOLD_HI;
      HOLD_HI:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Pin values for the upcoming state; on the accept edge the host inputs are
  // used directly so the SRAM address is valid from the first SETUP cycle.
  always_comb begin
    w_src_addr = w_accept ? wr_addr : r_addr;
    w_src_data = w_accept ? wr_data : r_data;
    w_base     = SRAM_ADDR_WIDTH'({w_src_addr, 1'b0});
    w_next_hi  = (w_next == SETUP_HI) || (w_next == WE_HI) || (w_next == HOLD_HI);
    w_next_we  = (w_next == WE_LO) || (w_next == WE_HI);
  end

  // State register and capture of the host word on a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= wr_addr;
        r_data <= wr_data;
      end
    end
  end

  // Registered SRAM pins, completion pulse and word counter, all derived from
  // the next state so every pin changes cleanly on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_addr  <= '0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      wr_done    <= 1'b0;
      word_count <= '0;
    end else begin
      sram_oe_n <= 1'b1;
      sram_ce_n <= (w_next == IDLE);
      sram_lb_n <= (w_next == IDLE);
      sram_ub_n <= (w_next == IDLE);
      sram_we_n <= !w_next_we;
      r_dq_oe   <= (w_next != IDLE);
      if (w_next != IDLE) begin
        sram_addr <= w_next_hi ? (w_base | SRAM_ADDR_WIDTH'(1)) : w_base;
        r_dq_out  <= w_next_hi ? w_src_data[2*SRAM_DATA_WIDTH-1:SRAM_DATA_WIDTH]
                               : w_src_data[SRAM_DATA_WIDTH-1:0];
      end
      wr_done <= (w_next == HOLD_HI);
      if (w_next == HOLD_HI) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_memory_loader.sv
// Scoreboard bench for inst_memory_loader: a tracker turns each handshake into
// expected halfword writes and completions, and a monitor checks the SRAM pins.
module tb_inst_memory_loader;

  localparam int IDW = 32;
  localparam int IAW = 20;
  localparam int SDW = 16;
  localparam int SAW = 20;

  typedef struct {
    logic [SAW-1:0] addr;
    logic [SDW-1:0] data;
  } half_t;

  typedef struct {
    int          cyc;
    logic [15:0] count;
  } done_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wrValid = 1'b0;
  logic           wrReady;
  logic [IAW-1:0] wrAddr = '0;
  logic [IDW-1:0] wrData = '0;
  logic           wrDone;
  logic [15:0]    wordCount;
  logic [SAW-1:0] sramAddr;
  wire  [SDW-1:0] sramDq;
  logic           ceN, oeN, weN, lbN, ubN;

  half_t writeQ[$];
  done_t doneQ[$];
  half_t weLog[$];
  int    acceptLog[$];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          wePulses = 0;
  int          lastDoneCyc = 0;
  int          presetGen = 0;
  int          seenGen = 0;
  bit          started = 1'b0;
  logic [15:0] modelCount = 16'd0;

  logic [SAW-1:0] prevAddr = '0;
  logic [SDW-1:0] prevDq = '0;
  logic           prevWe = 1'b1;
  logic           prevRst = 1'b0;
  bit             holdPending = 1'b0;
  logic [SAW-1:0] holdAddr = '0;
  logic [SDW-1:0] holdDq = '0;
  half_t          curHalf;
  done_t          curDone;

  logic [IAW-1:0] rndAddr;
  logic [IDW-1:0] rndData;
  int             n0, s0, w0;

  inst_memory_loader #(
    .INST_DATA_WIDTH(IDW),
    .INST_ADDR_WIDTH(IAW),
    .SRAM_DATA_WIDTH(SDW),
    .SRAM_ADDR_WIDTH(SAW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wrValid),
    .wr_ready(wrReady),
    .wr_addr(wrAddr),
    .wr_data(wrData),
    .wr_done(wrDone),
    .word_count(wordCount),
    .sram_addr(sramAddr),
    .sram_dq(sramDq),
    .sram_ce_n(ceN),
    .sram_oe_n(oeN),
    .sram_we_n(weN),
    .sram_lb_n(lbN),
    .sram_ub_n(ubN)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to time completions against handshakes.
  always @(posedge clk) cyc <= cyc + 1;

  // Halfword base address: word address times two, wrapped to the SRAM space.
  function automatic logic [SAW-1:0] modelBase(input logic [IAW-1:0] a);
    longint unsigned v;
    v = (longint'(a) * 2) % (longint'(1) << SAW);
    return v[SAW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Tracker: every handshake seen with reset released becomes two expected
  // halfword writes and one expected completion six cycles later.
  always @(negedge clk) begin
    if (started) begin
      if (presetGen != seenGen) begin
        seenGen = presetGen;
        modelCount = 16'hFFFF;
      end
      if (!rst_n) begin
        modelCount = 16'd0;
      end else if (wrValid && wrReady) begin
        writeQ.push_back('{modelBase(wrAddr), wrData[15:0]});
        writeQ.push_back('{modelBase(wrAddr) + SAW'(1), wrData[31:16]});
        modelCount = modelCount + 16'd1;
        doneQ.push_back('{cyc + 6, modelCount});
        acceptLog.push_back(cyc);
      end
    end
  end

  // Monitor: checks idle pins, each write strobe against the expected queue,
  // address/data stability around the strobe, and every completion pulse.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("oe_n_high", 64'(oeN), 64'd1);
      if (holdPending && prevRst) begin
        checkOutput("hold_we_n", 64'(weN), 64'd1);
        checkOutput("hold_addr", 64'(sramAddr), 64'(holdAddr));
        checkOutput("hold_dq", 64'(sramDq), 64'(holdDq));
      end
      holdPending = 1'b0;
      if (wrReady) begin
        checkOutput("idle_ce_n", 64'(ceN), 64'd1);
        checkOutput("idle_we_n", 64'(weN), 64'd1);
        checkOutput("idle_lb_ub_n", 64'({lbN, ubN}), 64'd3);
        checkOutput("idle_dq_z", 64'(sramDq === 16'hzzzz), 64'd1);
      end
      if (weN == 1'b0) begin
        wePulses++;
        weLog.push_back('{sramAddr, sramDq});
        checkOutput("we_ctrl_low", 64'({ceN, lbN, ubN}), 64'd0);
        checkOutput("we_single_cycle", 64'(prevWe), 64'd1);
        checkOutput("write_expected", 64'(writeQ.size() != 0), 64'd1);
        if (writeQ.size() != 0) begin
          curHalf = writeQ.pop_front();
          checkOutput("we_addr", 64'(sramAddr), 64'(curHalf.addr));
          checkOutput("we_dq", 64'(sramDq), 64'(curHalf.data));
          checkOutput("setup_addr", 64'(prevAddr), 64'(curHalf.addr));
          checkOutput("setup_dq", 64'(prevDq), 64'(curHalf.data));
          holdAddr = curHalf.addr;
          holdDq = curHalf.data;
          holdPending = 1'b1;
        end
      end
      if (wrDone) begin
        checkOutput("done_expected", 64'(doneQ.size() != 0), 64'd1);
        if (doneQ.size() != 0) begin
          curDone = doneQ.pop_front();
          checkOutput("done_cycle", 64'(cyc), 64'(curDone.cyc));
          checkOutput("done_count", 64'(wordCount), 64'(curDone.count));
          lastDoneCyc = cyc;
        end
      end else if (doneQ.size() != 0 && doneQ[0].cyc <= cyc) begin
        checkOutput("done_missing", 64'(wrDone), 64'd1);
        void'(doneQ.pop_front());
      end
      prevAddr = sramAddr;
      prevDq = sramDq;
      prevWe = weN;
      prevRst = rst_n;
      if (!rst_n) begin
        writeQ.delete();
        doneQ.delete();
        holdPending = 1'b0;
      end
    end
  end

  // Present one word and wait (bounded) for the handshake; returns just after
  // the accepting edge with the host inputs scrambled unless told to keep them.
  task automatic applyStimulus(input logic [IAW-1:0] a, input logic [IDW-1:0] d,
                               input bit keepValid);
    bit got;
    got = 1'b0;
    wrAddr = a;
    wrData = d;
    wrValid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (wrReady && rst_n) got = 1'b1;
    end
    checkOutput("accept_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    if (!keepValid) begin
      wrValid = 1'b0;
      wrAddr = IAW'($urandom);
      wrData = $urandom;
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (wrReady) idle = 1'b1;
    end
    checkOutput("idle_reached", 64'(idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 64'(wrReady), 64'd1);
    checkOutput("rst_done", 64'(wrDone), 64'd0);
    checkOutput("rst_count", 64'(wordCount), 64'd0);
    checkOutput("rst_ctrl_n", 64'({ceN, weN, oeN, lbN, ubN}), 64'h1F);
    checkOutput("rst_addr", 64'(sramAddr), 64'd0);
    checkOutput("rst_dq_z", 64'(sramDq === 16'hzzzz), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single write");
    n0 = weLog.size();
    applyStimulus(20'h00010, 32'hDEADBEEF, 1'b0);
    waitIdle();
    checkOutput("single_lo_addr", 64'(weLog[n0].addr), 64'h00020);
    checkOutput("single_lo_dq", 64'(weLog[n0].data), 64'hBEEF);
    checkOutput("single_hi_addr", 64'(weLog[n0+1].addr), 64'h00021);
    checkOutput("single_hi_dq", 64'(weLog[n0+1].data), 64'hDEAD);
    checkOutput("single_latency", 64'(lastDoneCyc - acceptLog[acceptLog.size()-1]), 64'd6);
    checkOutput("single_count", 64'(wordCount), 64'd1);

    $display("[TB] back-to-back writes");
    doReset();
    s0 = acceptLog.size();
    w0 = wePulses;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(IAW'($urandom), $urandom, 1'b1);
    end
    wrValid = 1'b0;
    waitIdle();
    checkOutput("b2b_accepts", 64'(acceptLog.size() - s0), 64'd3);
    checkOutput("b2b_gap1", 64'(acceptLog[s0+1] - acceptLog[s0]), 64'd7);
    checkOutput("b2b_gap2", 64'(acceptLog[s0+2] - acceptLog[s0+1]), 64'd7);
    checkOutput("b2b_we_pulses", 64'(wePulses - w0), 64'd6);
    checkOutput("b2b_count", 64'(wordCount), 64'd3);

    $display("[TB] address truncation");
    n0 = weLog.size();
    applyStimulus(20'hFFFFF, 32'h0BADF00D, 1'b0);
    waitIdle();
    checkOutput("trunc_lo_addr", 64'(weLog[n0].addr), 64'hFFFFE);
    checkOutput("trunc_hi_addr", 64'(weLog[n0+1].addr), 64'hFFFFF);

    $display("[TB] inputs changed while busy");
    n0 = weLog.size();
    applyStimulus(20'h00A55, 32'h12345678, 1'b0);
    wrData = 32'hA5A5A5A5;
    wrAddr = 20'h00777;
    waitIdle();
    checkOutput("busy_lo_dq", 64'(weLog[n0].data), 64'h5678);
    checkOutput("busy_hi_dq", 64'(weLog[n0+1].data), 64'h1234);
    checkOutput("busy_hi_addr", 64'(weLog[n0+1].addr), 64'h014AB);

    $display("[TB] reset during second strobe");
    applyStimulus(20'h00321, 32'hCAFEF00D, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_rst_we_n", 64'(weN), 64'd0);
    checkOutput("pre_rst_hi_addr", 64'(sramAddr), 64'h00643);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", 64'(wrReady), 64'd1);
    checkOutput("abort_we_n", 64'(weN), 64'd1);
    checkOutput("abort_ce_n", 64'(ceN), 64'd1);
    checkOutput("abort_dq_z", 64'(sramDq === 16'hzzzz), 64'd1);
    checkOutput("abort_done", 64'(wrDone), 64'd0);
    checkOutput("abort_count", 64'(wordCount), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("abort_count_later", 64'(wordCount), 64'd0);

    $display("[TB] counter wrap");
    waitIdle();
    force dut.word_count = 16'hFFFF;
    presetGen++;
    #1;
    release dut.word_count;
    applyStimulus(IAW'($urandom), $urandom, 1'b0);
    waitIdle();
    checkOutput("wrap_count", 64'(wordCount), 64'd0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 24; it++) begin
      rndAddr = IAW'($urandom);
      rndData = $urandom;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(rndAddr, rndData, 1'b0);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 5)) begin
          @(posedge clk);
          #1;
        end
        doReset();
      end else begin
        wrValid = 1'b1;
        wrAddr = IAW'($urandom);
        wrData = $urandom;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        wrValid = 1'b0;
      end
      waitIdle();
    end

    repeat (10) @(posedge clk);
    #1;
    checkOutput("final_count", 64'(wordCount), 64'(modelCount));
    checkOutput("writes_drained", 64'(writeQ.size()), 64'd0);
    checkOutput("dones_drained", 64'(doneQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
